// File: rtl/sitcp_tx_arbiter.sv
// Round-robin packet arbiter sharing the SiTCP TCP transmit byte stream among
// N_CH framed requesters, with an optional 2-byte channel header per packet.
module sitcp_tx_arbiter #(
    parameter int         N_CH      = 4,
    parameter bit         HDR_EN    = 1'b1,
    parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tcp_open,
    input  logic              i_tcp_rst,
    input  logic              i_tcp_tx_full,
    output logic              o_tcp_tx_wr,
    output logic [7:0]        o_tcp_tx_data,
    input  logic [N_CH-1:0]   i_req_valid,
    input  logic [8*N_CH-1:0] i_req_data,
    input  logic [N_CH-1:0]   i_req_last,
    output logic [N_CH-1:0]   o_req_ready,
    output logic [N_CH-1:0]   o_grant,
    output logic              o_busy,
    output logic [15:0]       o_abort_cnt,
    output logic [31:0]       o_tx_byte_cnt
);

    // state  | meaning
    // IDLE   | no grant; pick next valid channel when the connection is up
    // HDR0   | emit HDR_MAGIC
    // HDR1   | emit {5'b0, ch}
    // DATA   | forward granted channel bytes to SiTCP
    // FLUSH  | connection lost; swallow rest of packet without writing
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_ch;
    logic [2:0]        r_rr_ptr;
    logic [N_CH-1:0]   r_grant;
    logic              r_tx_wr;
    logic [7:0]        r_tx_data;
    logic [15:0]       r_abort_cnt;
    logic [31:0]       r_tx_byte_cnt;

    logic              w_ok;
    logic              w_found;
    logic [2:0]        w_sel;
    logic              w_g_valid;
    logic              w_g_last;
    logic [7:0]        w_g_data;
    logic              w_rdy;
    logic              w_accept;
    logic              w_wr_en;
    logic [7:0]        w_wr_data;
    logic              w_abort;
    logic              w_do_grant;
    logic              w_release;
    logic [2:0]        w_rr_nxt;

    assign w_ok = i_tcp_open & ~i_tcp_rst;

    // First valid channel at or above r_rr_ptr, wrapping modulo N_CH.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        for (int i = 0; i < N_CH; i++) begin
            for (int j = 0; j < N_CH; j++) begin
                if (!w_found && (((int'(r_rr_ptr) + i) % N_CH) == j) && i_req_valid[j]) begin
                    w_found = 1'b1;
                    w_sel   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = 8'd0;
        for (int j = 0; j < N_CH; j++) begin
            if (r_ch == 3'(j)) begin
                w_g_valid = i_req_valid[j];
                w_g_last  = i_req_last[j];
                w_g_data  = i_req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        w_rdy = 1'b0;
        case (r_state)
            S_DATA:  w_rdy = w_ok & ~i_tcp_tx_full;
            S_FLUSH: w_rdy = 1'b1;
            default: w_rdy = 1'b0;
        endcase
    end

    assign o_req_ready = r_grant & {N_CH{w_rdy}};
    assign w_accept    = w_g_valid & w_rdy;
    assign w_rr_nxt    = (r_ch == 3'(N_CH - 1)) ? 3'd0 : r_ch + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_data   = r_tx_data;
        w_abort     = 1'b0;
        w_do_grant  = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ok && w_found) begin
                    w_do_grant  = 1'b1;
                    w_state_nxt = HDR_EN ? S_HDR0 : S_DATA;
                end
            end
            S_HDR0: begin
                if (!w_ok) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_FLUSH;
                end else if (!i_tcp_tx_full) begin
                    w_wr_en     = 1'b1;
                    w_wr_data   = HDR_MAGIC;
                    w_state_nxt = S_HDR1;
                end
            end
            S_HDR1: begin
                if (!w_ok) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_FLUSH;
                end else if (!i_tcp_tx_full) begin
                    w_wr_en     = 1'b1;
                    w_wr_data   = {5'b0, r_ch};
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (!w_ok) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_FLUSH;
                end else if (w_accept) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_g_data;
                    if (w_g_last) begin
                        w_release   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (w_accept && w_g_last) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_ch          <= 3'd0;
            r_rr_ptr      <= 3'd0;
            r_grant       <= '0;
            r_tx_wr       <= 1'b0;
            r_tx_data     <= 8'd0;
            r_abort_cnt   <= 16'd0;
            r_tx_byte_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tx_wr <= w_wr_en;
            if (w_wr_en) begin
                r_tx_data     <= w_wr_data;
                r_tx_byte_cnt <= r_tx_byte_cnt + 32'd1;
            end
            if (w_abort && (r_abort_cnt != 16'hFFFF)) begin
                r_abort_cnt <= r_abort_cnt + 16'd1;
            end
            if (w_do_grant) begin
                r_ch    <= w_sel;
                r_grant <= {{(N_CH-1){1'b0}}, 1'b1} << w_sel;
            end else if (w_release) begin
                r_grant  <= '0;
                r_rr_ptr <= w_rr_nxt;
            end
        end
    end

    assign o_tcp_tx_wr   = r_tx_wr;
    assign o_tcp_tx_data = r_tx_data;
    assign o_grant       = r_grant;
    assign o_busy        = (r_state != S_IDLE);
    assign o_abort_cnt   = r_abort_cnt;
    assign o_tx_byte_cnt = r_tx_byte_cnt;

endmodule
